// File: rtl/line_clear_sequencer.sv
// Board owner for a falling-block game: merges a locked piece, removes full
// rows one at a time from the bottom up, keeps the score and flags game over.
module line_clear_sequencer #(
    parameter int unsigned ROWS    = 23,
    parameter int unsigned COLS    = 10,
    parameter int unsigned SCORE_W = 10
) (
    input  logic                     clk_50,
    input  logic                     resetn,
    input  logic                     clear,
    input  logic                     lock_req,
    input  logic [3:0]               t0_x,
    input  logic [3:0]               t1_x,
    input  logic [3:0]               t2_x,
    input  logic [3:0]               t3_x,
    input  logic [4:0]               t0_y,
    input  logic [4:0]               t1_y,
    input  logic [4:0]               t2_y,
    input  logic [4:0]               t3_y,
    output logic                     lock_ack,
    output logic                     busy,
    output logic                     done,
    output logic [2:0]               lines_cleared,
    output logic [SCORE_W-1:0]       score,
    output logic                     gameover,
    output logic [ROWS*COLS-1:0]     board_value
);

    localparam int unsigned PTR_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned TILES   = 4;
    localparam logic [2:0]  CNT_MAX = 3'd7;
    localparam logic [SCORE_W:0] SCORE_MAX = {1'b0, {SCORE_W{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MERGE,
        S_SCAN,
        S_SHIFT,
        S_DONE,
        S_OVER
    } state_t;

    state_t state;
    state_t state_next;

    logic [COLS-1:0]  rows [ROWS];
    logic [COLS-1:0]  hit  [ROWS];
    logic [3:0]       lx   [TILES];
    logic [4:0]       ly   [TILES];
    logic [PTR_W-1:0] row_ptr;
    logic [2:0]       cnt;
    logic             row_full;
    logic             top_used;
    logic [SCORE_W:0] score_sum;

    // Row y is stored with column 0 in its MSB, matching the flattened layout.
    for (genvar g = 0; g < ROWS; g++) begin : g_flat
        assign board_value[g*COLS +: COLS] = rows[g];
    end

    // Status of the row under the scan pointer, top row occupancy, score sum.
    always_comb begin
        row_full  = (rows[row_ptr] == {COLS{1'b1}});
        top_used  = |rows[0];
        score_sum = {1'b0, score} + (SCORE_W+1)'(cnt);
    end

    // Cells addressed by the latched tiles; out-of-range tiles match nothing.
    always_comb begin
        for (int unsigned y = 0; y < ROWS; y++) begin
            hit[y] = '0;
        end
        for (int unsigned t = 0; t < TILES; t++) begin
            for (int unsigned y = 0; y < ROWS; y++) begin
                for (int unsigned x = 0; x < COLS; x++) begin
                    if (32'(lx[t]) == x && 32'(ly[t]) == y) begin
                        hit[y][COLS-1-x] = 1'b1;
                    end
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk_50) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; clear aborts any sequence back to IDLE.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (lock_req) state_next = S_MERGE;
                S_MERGE: state_next = S_SCAN;
                S_SCAN: begin
                    if (row_full) begin
                        state_next = S_SHIFT;
                    end else if (row_ptr == '0) begin
                        state_next = S_DONE;
                    end
                end
                S_SHIFT: state_next = S_SCAN;
                S_DONE:  state_next = top_used ? S_OVER : S_IDLE;
                S_OVER:  state_next = S_OVER;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Handshake outputs, registered.
    always_ff @(posedge clk_50) begin
        if (!resetn || clear) begin
            lock_ack <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            lock_ack <= (state == S_IDLE) && lock_req;
            done     <= (state == S_DONE);
            busy     <= state_next inside {S_MERGE, S_SCAN, S_SHIFT, S_DONE};
        end
    end

    // Capture tile coordinates when a request is accepted.
    always_ff @(posedge clk_50) begin
        if (state == S_IDLE && lock_req) begin
            lx[0] <= t0_x;  ly[0] <= t0_y;
            lx[1] <= t1_x;  ly[1] <= t1_y;
            lx[2] <= t2_x;  ly[2] <= t2_y;
            lx[3] <= t3_x;  ly[3] <= t3_y;
        end
    end

    // Board, scan pointer and per-sequence row counter.
    always_ff @(posedge clk_50) begin
        if (!resetn || clear) begin
            for (int unsigned y = 0; y < ROWS; y++) begin
                rows[y] <= '0;
            end
            row_ptr <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                S_MERGE: begin
                    for (int unsigned y = 0; y < ROWS; y++) begin
                        rows[y] <= rows[y] | hit[y];
                    end
                    row_ptr <= PTR_W'(ROWS - 1);
                    cnt     <= '0;
                end
                S_SCAN: begin
                    if (!row_full && row_ptr != '0) begin
                        row_ptr <= row_ptr - 1'b1;
                    end
                end
                S_SHIFT: begin
                    for (int unsigned r = 1; r < ROWS; r++) begin
                        if (32'(row_ptr) >= r) begin
                            rows[r] <= rows[r-1];
                        end
                    end
                    rows[0] <= '0;
                    if (cnt != CNT_MAX) begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Score, last-sequence line count and sticky game-over flag.
    always_ff @(posedge clk_50) begin
        if (!resetn) begin
            score         <= '0;
            gameover      <= 1'b0;
            lines_cleared <= '0;
        end else if (clear) begin
            score    <= '0;
            gameover <= 1'b0;
        end else if (state == S_DONE) begin
            lines_cleared <= cnt;
            score         <= (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}}
                                                     : score_sum[SCORE_W-1:0];
            if (top_used) begin
                gameover <= 1'b1;
            end
        end
    end

endmodule
